// File: rtl/ring_phase_monitor_if.sv
// ----------------------------------------------------------------------------
// ring_phase_monitor_if
// Groups the ring bus and the health/status outputs of ring_phase_monitor.
//   master : driver side (ring source + clear), observes the status outputs
//   slave  : the monitor itself
// Signals:
//   ring_in    one-hot ring counter output (WIDTH)
//   clr        sync clear of rev_cnt, err_cnt, err_sticky
//   locked     monitor is locked onto the sequence
//   phase      index of the hot bit of the last legal one-hot sample
//   rev_cnt    completed revolutions while locked (wraps)
//   err        one-cycle pulse per detected error
//   err_sticky set on first error, held until clr/reset
//   err_cnt    saturating error count
//   dir        rotation direction, only with RING_MON_BIDIR_EN (1 = right)
// ----------------------------------------------------------------------------
interface ring_phase_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
);
  localparam int PW = $clog2(WIDTH);

  logic [WIDTH-1:0] ring_in;
  logic             clr;
  logic             locked;
  logic [PW-1:0]    phase;
  logic [CNT_W-1:0] rev_cnt;
  logic             err;
  logic             err_sticky;
  logic [ERR_W-1:0] err_cnt;
`ifdef RING_MON_BIDIR_EN
  logic             dir;

  modport master (output ring_in, clr,
                  input  locked, phase, rev_cnt, err, err_sticky, err_cnt, dir);
  modport slave  (input  ring_in, clr,
                  output locked, phase, rev_cnt, err, err_sticky, err_cnt, dir);
`else
  modport master (output ring_in, clr,
                  input  locked, phase, rev_cnt, err, err_sticky, err_cnt);
  modport slave  (input  ring_in, clr,
                  output locked, phase, rev_cnt, err, err_sticky, err_cnt);
`endif
endinterface

// File: rtl/ring_phase_monitor.sv
// ----------------------------------------------------------------------------
// ring_phase_monitor
// Watches a one-hot ring counter bus, locks onto its rotation, reports the
// current phase, counts revolutions and flags sequence errors.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   mon  ring_phase_monitor_if.slave (ring_in/clr in, status out)
// Optional feature: define RING_MON_BIDIR_EN to accept either rotation
// direction; the direction is latched during sync and exported on mon.dir.
// ----------------------------------------------------------------------------
module ring_phase_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int CNT_W    = 16,
  parameter int ERR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ring_phase_monitor_if.slave  mon
);
  localparam int PW = $clog2(WIDTH);
  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {UNLOCKED, SYNC, LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [GW-1:0]    r_g, w_g_nxt, w_g_inc;
  logic [WIDTH-1:0] r_s;
  logic [PW-1:0]    r_phase, w_idx;
  logic [CNT_W-1:0] r_rev;
  logic [ERR_W-1:0] r_errcnt;
  logic             r_err, r_sticky;

  logic w_onehot, w_hold, w_adv_l, w_adv, w_sync_adv, w_wrap, w_err, w_rev;

`ifdef RING_MON_BIDIR_EN
  logic r_dir, w_dir_nxt;
  logic r_dvld, w_dvld_nxt;   // direction latched in the current sync episode
  logic w_adv_r;
`endif

  // Classification of the current sample against the previous one
  assign w_onehot = (mon.ring_in != '0) &&
                    ((mon.ring_in & (mon.ring_in - WIDTH'(1))) == '0);
  assign w_hold   = w_onehot && (mon.ring_in == r_s);
  assign w_adv_l  = w_onehot && (mon.ring_in == {r_s[WIDTH-2:0], r_s[WIDTH-1]});
  assign w_g_inc  = r_g + GW'(1);

`ifdef RING_MON_BIDIR_EN
  assign w_adv_r    = w_onehot && (mon.ring_in == {r_s[0], r_s[WIDTH-1:1]});
  assign w_adv      = r_dir ? w_adv_r : w_adv_l;
  // Until a direction is latched, either rotation counts as progress
  assign w_sync_adv = r_dvld ? w_adv : (w_adv_l | w_adv_r);
  assign w_wrap     = r_dir ? mon.ring_in[WIDTH-1] : mon.ring_in[0];
`else
  assign w_adv      = w_adv_l;
  assign w_sync_adv = w_adv_l;
  assign w_wrap     = mon.ring_in[0];
`endif

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (mon.ring_in[i]) w_idx = PW'(i);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_err       = 1'b0;
    w_rev       = 1'b0;
`ifdef RING_MON_BIDIR_EN
    w_dir_nxt   = r_dir;
    w_dvld_nxt  = r_dvld;
`endif
    case (r_state)
      UNLOCKED: begin
        if (w_onehot) begin
          w_state_nxt = SYNC;
          w_g_nxt     = '0;
`ifdef RING_MON_BIDIR_EN
          w_dvld_nxt  = 1'b0;
`endif
        end
      end
      SYNC: begin
        if (!w_onehot) begin
          w_state_nxt = UNLOCKED;
        end else if (w_sync_adv) begin
          w_g_nxt = w_g_inc;
          if (w_g_inc == GW'(LOCK_CNT)) w_state_nxt = LOCKED;
`ifdef RING_MON_BIDIR_EN
          if (!r_dvld) begin
            w_dvld_nxt = 1'b1;
            w_dir_nxt  = !w_adv_l;
          end
`endif
        end else if (!w_hold) begin
          w_g_nxt = '0;
        end
      end
      LOCKED: begin
        if (w_adv) begin
          w_rev = w_wrap;
        end else if (!w_hold) begin
          w_err       = 1'b1;
          w_state_nxt = UNLOCKED;
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= UNLOCKED;
      r_g     <= '0;
`ifdef RING_MON_BIDIR_EN
      r_dir   <= 1'b0;
      r_dvld  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
`ifdef RING_MON_BIDIR_EN
      r_dir   <= w_dir_nxt;
      r_dvld  <= w_dvld_nxt;
`endif
    end
  end

  // Registered outputs; clr wins over increments but not over the err pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s      <= '0;
      r_phase  <= '0;
      r_rev    <= '0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_errcnt <= '0;
    end else begin
      r_s   <= mon.ring_in;
      r_err <= w_err;
      if (w_onehot) r_phase <= w_idx;
      if (mon.clr) begin
        r_rev    <= '0;
        r_sticky <= 1'b0;
        r_errcnt <= '0;
      end else begin
        if (w_rev) r_rev <= r_rev + CNT_W'(1);
        if (w_err) begin
          r_sticky <= 1'b1;
          if (r_errcnt != '1) r_errcnt <= r_errcnt + ERR_W'(1);
        end
      end
    end
  end

  assign mon.locked     = (r_state == LOCKED);
  assign mon.phase      = r_phase;
  assign mon.rev_cnt    = r_rev;
  assign mon.err        = r_err;
  assign mon.err_sticky = r_sticky;
  assign mon.err_cnt    = r_errcnt;
`ifdef RING_MON_BIDIR_EN
  assign mon.dir        = r_dir;
`endif

endmodule

// File: tb/tb_ring_phase_monitor.sv
// ----------------------------------------------------------------------------
// tb_ring_phase_monitor
// Directed bench for ring_phase_monitor (WIDTH=4, LOCK_CNT=2, ERR_W=8).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit after the edge that registered the sample.
// ----------------------------------------------------------------------------
module tb_ring_phase_monitor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ring_phase_monitor_if #(.WIDTH(4), .CNT_W(16), .ERR_W(8)) bus ();

  ring_phase_monitor #(.WIDTH(4), .LOCK_CNT(2), .CNT_W(16), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one sample and wait until its registered result is visible
  task automatic drive(input logic [3:0] v);
    bus.ring_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ring_in = 4'b1011;
    bus.clr     = 1'b0;

    // Reset with random bus activity
    for (int i = 0; i < 4; i++) begin
      bus.ring_in = 4'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_locked", bus.locked, 0);
    chk("rst_phase", bus.phase, 0);
    chk("rst_rev", bus.rev_cnt, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_sticky", bus.err_sticky, 0);
    chk("rst_errcnt", bus.err_cnt, 0);
`ifdef RING_MON_BIDIR_EN
    chk("rst_dir", bus.dir, 0);
`endif
    rst = 1'b1;

    // Constant zero while unlocked: no lock, no error
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000);
      chk("zero_locked", bus.locked, 0);
      chk("zero_err", bus.err, 0);
    end

    // Lock and count revolutions
    drive(4'b0001); chk("t2_ph0", bus.phase, 0); chk("t2_lk0", bus.locked, 0);
    drive(4'b0010); chk("t2_ph1", bus.phase, 1); chk("t2_lk1", bus.locked, 0);
    drive(4'b0100); chk("t2_ph2", bus.phase, 2); chk("t2_lk2", bus.locked, 1);
    drive(4'b1000); chk("t2_ph3", bus.phase, 3); chk("t2_rev0", bus.rev_cnt, 0);
    drive(4'b0001); chk("t2_ph0b", bus.phase, 0); chk("t2_rev1", bus.rev_cnt, 1);
    drive(4'b0010); drive(4'b0100); drive(4'b1000);
    chk("t2_rev1b", bus.rev_cnt, 1);
    drive(4'b0001); chk("t2_rev2", bus.rev_cnt, 2);

    // Hold while locked
    drive(4'b0010); drive(4'b0100);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100);
      chk("t3_lk", bus.locked, 1);
      chk("t3_err", bus.err, 0);
      chk("t3_ph", bus.phase, 2);
    end
    drive(4'b1000);
    chk("t3_ph3", bus.phase, 3); chk("t3_lk3", bus.locked, 1); chk("t3_err3", bus.err, 0);

    // Illegal value while locked
    drive(4'b0110);
    chk("t4_err", bus.err, 1); chk("t4_sticky", bus.err_sticky, 1);
    chk("t4_cnt", bus.err_cnt, 1); chk("t4_lk", bus.locked, 0);
    chk("t4_ph", bus.phase, 3); chk("t4_rev", bus.rev_cnt, 2);
    drive(4'b0001); chk("t4_pulse", bus.err, 0); chk("t4_lkA", bus.locked, 0);
    drive(4'b0010); chk("t4_lkB", bus.locked, 0);
    drive(4'b0100); chk("t4_relock", bus.locked, 1); chk("t4_sticky2", bus.err_sticky, 1);

    // 299 more errors; lock completes on a wrap that must not count
    for (int i = 0; i < 299; i++) begin
      drive(4'b0110);
      if (i == 252) chk("t5_cnt254", bus.err_cnt, 254);
      if (i == 253) chk("t5_cnt255", bus.err_cnt, 255);
      drive(4'b0100); drive(4'b1000); drive(4'b0001);
      if (i == 0) begin
        chk("t5_lock", bus.locked, 1);
        chk("t5_norev", bus.rev_cnt, 2);
      end
    end
    chk("t5_sat", bus.err_cnt, 255);
    chk("t5_lk_end", bus.locked, 1);

    // clr together with an error
    bus.clr = 1'b1;
    drive(4'b0110);
    bus.clr = 1'b0;
    chk("t5_clr_err", bus.err, 1); chk("t5_clr_cnt", bus.err_cnt, 0);
    chk("t5_clr_sticky", bus.err_sticky, 0); chk("t5_clr_rev", bus.rev_cnt, 0);
    drive(4'b0001); chk("t5_after_err", bus.err, 0); chk("t5_after_sticky", bus.err_sticky, 0);

    // clr together with a revolution increment
    drive(4'b0010); drive(4'b0100); drive(4'b1000);
    chk("clr_rev_lk", bus.locked, 1);
    bus.clr = 1'b1;
    drive(4'b0001);
    bus.clr = 1'b0;
    chk("clr_rev0", bus.rev_cnt, 0); chk("clr_lk", bus.locked, 1);
    drive(4'b0010); drive(4'b0100); drive(4'b1000); drive(4'b0001);
    chk("clr_rev1", bus.rev_cnt, 1);

    // Constant zero while locked is an error
    drive(4'b0000);
    chk("zero_lk_err", bus.err, 1); chk("zero_lk_cnt", bus.err_cnt, 1);
    chk("zero_lk_lk", bus.locked, 0); chk("zero_lk_ph", bus.phase, 0);

    // Asynchronous reset mid-operation, then fresh re-lock
    drive(4'b0001); drive(4'b0010); drive(4'b0100);
    chk("mid_lk", bus.locked, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_lk", bus.locked, 0); chk("mid_rst_cnt", bus.err_cnt, 0);
    chk("mid_rst_rev", bus.rev_cnt, 0); chk("mid_rst_ph", bus.phase, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(4'b1000); chk("mid_rl0", bus.locked, 0);
    drive(4'b0001); chk("mid_rl1", bus.locked, 0);
    drive(4'b0010); chk("mid_rl2", bus.locked, 1);

    // Right rotation
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef RING_MON_BIDIR_EN
    drive(4'b1000); drive(4'b0100);
    chk("bd_lk1", bus.locked, 0); chk("bd_dir", bus.dir, 1);
    drive(4'b0010); chk("bd_lk2", bus.locked, 1);
    drive(4'b0001); chk("bd_rev0", bus.rev_cnt, 0);
    drive(4'b1000); chk("bd_rev1", bus.rev_cnt, 1); chk("bd_ph", bus.phase, 3);
    drive(4'b0100); drive(4'b0010); drive(4'b0001);
    drive(4'b0010);
    chk("bd_err", bus.err, 1); chk("bd_errlk", bus.locked, 0);
`else
    drive(4'b1000); drive(4'b0100); drive(4'b0010); drive(4'b0001);
    chk("right_nolock", bus.locked, 0); chk("right_noerr", bus.err, 0);
    chk("right_ph", bus.phase, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
